level_tile_arbiter: RTL and testbench

Owns the single-port level tile memory and shares it between two requesters.
- Display path: prefetches the tile under the upcoming raster position and drives the per-pixel blockType consumed by the display controller.
- Physics/collision logic: issues random tile lookups.
- Display has strict priority. The active level is switched only at frame boundaries.

---
 rtl/level_tile_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_level_tile_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/level_tile_arbiter.sv
// Shares the single-port level tile memory between the display prefetch path (strict priority)
// and random physics lookups; also produces the per-pixel blockType for the display controller.
module level_tile_arbiter #(
    parameter int unsigned COLS     = 20,
    parameter int unsigned ROWS     = 15,
    parameter int unsigned H_OFFSET = 144,
    parameter int unsigned V_OFFSET = 35,
    parameter int unsigned PREFETCH = 4,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStart,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic [1:0]        levelSel,
    input  logic              physReq,
    input  logic [4:0]        physCol,
    input  logic [3:0]        physRow,
    output logic              physAck,
    output logic [2:0]        physBlockType,
    output logic              memEn,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [2:0]        memRdata,
    output logic [2:0]        blockType
);
    localparam int unsigned GRID_W      = COLS * 32;
    localparam int unsigned GRID_H      = ROWS * 32;
    localparam int unsigned LEVEL_TILES = COLS * ROWS;

    // Registered state
    logic [1:0] level_q, level_d;
    logic       pf_valid_q, pf_valid_d;
    logic [5:0] pf_col_q, pf_col_d, pf_row_q, pf_row_d;
    logic [2:0] next_tile_q, next_tile_d;
    logic       disp_valid_q, disp_valid_d;
    logic [5:0] disp_col_q, disp_col_d, disp_row_q, disp_row_d;
    logic [2:0] block_d;
    logic       mem_en_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic       ack_d;
    logic [2:0] phys_bt_d;

    // Read pipeline: s1 = cycle memEn is high, s2 = cycle memRdata is valid
    logic       s1_valid_q, s1_valid_d, s1_phys_q, s1_phys_d, s1_oor_q, s1_oor_d;
    logic [5:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;
    logic       s2_valid_q, s2_phys_q, s2_oor_q;
    logic [5:0] s2_col_q, s2_row_q;

    // Raster-derived combinational signals
    logic [9:0]  px, py;
    logic [10:0] px_ahead, py_next;
    logic        in_grid;
    logic [5:0]  cur_col, cur_row, tgt_col, tgt_row;
    logic        tgt_empty, disp_busy, disp_need, disp_go;
    logic        phys_busy, phys_oor, phys_go;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [1:0] lvl,
                                                    input logic [5:0] row,
                                                    input logic [5:0] col);
        return ADDR_W'(32'(lvl) * LEVEL_TILES + 32'(row) * COLS + 32'(col));
    endfunction

    // Raster position, current tile and prefetch target
    always_comb begin
        px       = hCount - 10'(H_OFFSET);
        py       = vCount - 10'(V_OFFSET);
        px_ahead = 11'(px) + 11'(PREFETCH);
        py_next  = 11'(py) + 11'd1;
        in_grid  = (32'(px) < GRID_W) && (32'(py) < GRID_H);
        cur_col  = 6'(px >> 5);
        cur_row  = 6'(py >> 5);
        if (32'(px_ahead) < GRID_W) begin
            tgt_col = 6'(px_ahead >> 5);
            tgt_row = 6'(py >> 5);
        end else begin
            tgt_col = 6'd0;
            tgt_row = 6'(py_next >> 5);
        end
        tgt_empty = 32'(tgt_row) >= ROWS;
        disp_busy = (s1_valid_q && !s1_phys_q) || (s2_valid_q && !s2_phys_q);
        disp_need = (!pf_valid_q || tgt_col != pf_col_q || tgt_row != pf_row_q) && !disp_busy;
        disp_go   = disp_need && !tgt_empty;
        phys_busy = (s1_valid_q && s1_phys_q) || (s2_valid_q && s2_phys_q) || physAck;
        phys_oor  = (32'(physCol) >= COLS) || (32'(physRow) >= ROWS);
        phys_go   = physReq && !phys_busy && !disp_go;
    end

    // Next-state: arbitration, read returns and displayed tile update
    always_comb begin
        level_d      = level_q;
        pf_valid_d   = pf_valid_q;
        pf_col_d     = pf_col_q;
        pf_row_d     = pf_row_q;
        next_tile_d  = next_tile_q;
        disp_valid_d = disp_valid_q;
        disp_col_d   = disp_col_q;
        disp_row_d   = disp_row_q;
        block_d      = blockType;
        mem_en_d     = 1'b0;
        mem_addr_d   = memAddr;
        ack_d        = 1'b0;
        phys_bt_d    = physBlockType;
        s1_valid_d   = 1'b0;
        s1_phys_d    = 1'b0;
        s1_oor_d     = 1'b0;
        s1_col_d     = 6'd0;
        s1_row_d     = 6'd0;

        if (frameStart) begin
            level_d = levelSel;
        end

        if (disp_go) begin
            mem_en_d   = 1'b1;
            mem_addr_d = tile_addr(level_q, tgt_row, tgt_col);
            s1_valid_d = 1'b1;
            s1_col_d   = tgt_col;
            s1_row_d   = tgt_row;
        end else if (phys_go) begin
            mem_en_d   = !phys_oor;
            if (!phys_oor) begin
                mem_addr_d = tile_addr(level_q, 6'(physRow), 6'(physCol));
            end
            s1_valid_d = 1'b1;
            s1_phys_d  = 1'b1;
            s1_oor_d   = phys_oor;
        end

        // Targets below the last row resolve immediately to an empty tile
        if (disp_need && tgt_empty) begin
            pf_valid_d  = 1'b1;
            pf_col_d    = tgt_col;
            pf_row_d    = tgt_row;
            next_tile_d = 3'd0;
        end

        if (s2_valid_q) begin
            if (s2_phys_q) begin
                ack_d     = 1'b1;
                phys_bt_d = s2_oor_q ? 3'd0 : memRdata;
            end else begin
                next_tile_d = memRdata;
                pf_valid_d  = 1'b1;
                pf_col_d    = s2_col_q;
                pf_row_d    = s2_row_q;
            end
        end

        if (in_grid) begin
            if (!disp_valid_q || cur_col != disp_col_q || cur_row != disp_row_q) begin
                block_d      = next_tile_q;
                disp_valid_d = 1'b1;
                disp_col_d   = cur_col;
                disp_row_d   = cur_row;
            end
        end else begin
            block_d      = 3'd0;
            disp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q       <= 2'd0;
            pf_valid_q    <= 1'b0;
            pf_col_q      <= 6'd0;
            pf_row_q      <= 6'd0;
            next_tile_q   <= 3'd0;
            disp_valid_q  <= 1'b0;
            disp_col_q    <= 6'd0;
            disp_row_q    <= 6'd0;
            blockType     <= 3'd0;
            memEn         <= 1'b0;
            memAddr       <= '0;
            physAck       <= 1'b0;
            physBlockType <= 3'd0;
            s1_valid_q    <= 1'b0;
            s1_phys_q     <= 1'b0;
            s1_oor_q      <= 1'b0;
            s1_col_q      <= 6'd0;
            s1_row_q      <= 6'd0;
            s2_valid_q    <= 1'b0;
            s2_phys_q     <= 1'b0;
            s2_oor_q      <= 1'b0;
            s2_col_q      <= 6'd0;
            s2_row_q      <= 6'd0;
        end else begin
            level_q       <= level_d;
            pf_valid_q    <= pf_valid_d;
            pf_col_q      <= pf_col_d;
            pf_row_q      <= pf_row_d;
            next_tile_q   <= next_tile_d;
            disp_valid_q  <= disp_valid_d;
            disp_col_q    <= disp_col_d;
            disp_row_q    <= disp_row_d;
            blockType     <= block_d;
            memEn         <= mem_en_d;
            memAddr       <= mem_addr_d;
            physAck       <= ack_d;
            physBlockType <= phys_bt_d;
            s1_valid_q    <= s1_valid_d;
            s1_phys_q     <= s1_phys_d;
            s1_oor_q      <= s1_oor_d;
            s1_col_q      <= s1_col_d;
            s1_row_q      <= s1_row_d;
            s2_valid_q    <= s1_valid_q;
            s2_phys_q     <= s1_phys_q;
            s2_oor_q      <= s1_oor_q;
            s2_col_q      <= s1_col_q;
            s2_row_q      <= s1_row_q;
        end
    end

endmodule

// File: tb/tb_level_tile_arbiter.sv
// Directed + randomized bench for level_tile_arbiter with a behavioural tile-memory model.
module tb_level_tile_arbiter;
    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset, frameStart, physReq;
    logic [9:0]        hCount, vCount;
    logic [1:0]        levelSel;
    logic [4:0]        physCol;
    logic [3:0]        physRow;
    logic              physAck, memEn;
    logic [2:0]        physBlockType, memRdata, blockType;
    logic [ADDR_W-1:0] memAddr;

    logic [2:0] mem [0:2047];
    int errors = 0;
    int checks = 0;

    level_tile_arbiter dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .hCount(hCount), .vCount(vCount),
        .levelSel(levelSel), .physReq(physReq), .physCol(physCol), .physRow(physRow),
        .physAck(physAck), .physBlockType(physBlockType), .memEn(memEn), .memAddr(memAddr),
        .memRdata(memRdata), .blockType(blockType)
    );

    always #5 clk = ~clk;

    // Single-port memory: data one cycle after enable, garbage otherwise
    always @(posedge clk) memRdata <= memEn ? mem[memAddr] : 3'($urandom);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tile visible at raster (h,v) for a level, straight from the geometry rules
    function automatic logic [2:0] exp_tile(input int lvl, input int h, input int v);
        int px = (h - 144 + 1024) % 1024;
        int py = (v - 35 + 1024) % 1024;
        if (px < 640 && py < 480) return mem[lvl * 300 + (py / 32) * 20 + px / 32];
        return 3'd0;
    endfunction

    task automatic set_level(input int lvl);
        hCount = 10'd0; vCount = 10'd0;
        levelSel = 2'(lvl); frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
        tick();
    endtask

    task automatic phys_txn(input int col, input int row, input int lvl);
        bit oor = (col >= 20) || (row >= 15);
        int a = lvl * 300 + row * 20 + col;
        logic [2:0] e = oor ? 3'd0 : mem[a];
        hCount = 10'd0; vCount = 10'd0;
        physCol = 5'(col); physRow = 4'(row); physReq = 1'b1;
        tick();
        chk("phys_memEn", 32'(memEn), 32'(!oor));
        if (!oor) chk("phys_addr", 32'(memAddr), 32'(a));
        tick();
        chk("phys_ack_early", 32'(physAck), 32'(0));
        chk("phys_one_read", 32'(memEn), 32'(0));
        tick();
        chk("phys_ack", 32'(physAck), 32'(1));
        chk("phys_data", 32'(physBlockType), 32'(e));
        physReq = 1'b0;
        tick();
        chk("phys_ack_pulse", 32'(physAck), 32'(0));
    endtask

    // One full raster line; optionally collides a physics request with the tile-2 prefetch
    task automatic sweep_line(input int v, input int lvl, input bit contend,
                              output int n_mem, output int bad_addr);
        int pc = $urandom_range(0, 19);
        int pr = $urandom_range(0, 14);
        int pa = lvl * 300 + pr * 20 + pc;
        int drow = ((v - 35 + 1024) % 1024) / 32;
        n_mem = 0;
        bad_addr = 0;
        for (int h = 0; h < 800; h++) begin
            hCount = 10'(h); vCount = 10'(v);
            if (contend && h == 204) begin
                physCol = 5'(pc); physRow = 4'(pr); physReq = 1'b1;
            end
            if (contend && h == 208) physReq = 1'b0;
            tick();
            chk("blockType", 32'(blockType), 32'(exp_tile(lvl, h, v)));
            if (memEn === 1'b1 && !(contend && h == 205)) begin
                n_mem++;
                if (int'(memAddr) < lvl * 300 || int'(memAddr) >= lvl * 300 + 300) bad_addr++;
            end
            if (contend) begin
                if (h == 204) begin
                    chk("cont_disp_en", 32'(memEn), 32'(1));
                    chk("cont_disp_addr", 32'(memAddr), 32'(lvl * 300 + drow * 20 + 2));
                end
                if (h == 205) begin
                    chk("cont_phys_en", 32'(memEn), 32'(1));
                    chk("cont_phys_addr", 32'(memAddr), 32'(pa));
                end
                if (h == 206) chk("cont_ack_early", 32'(physAck), 32'(0));
                if (h == 207) begin
                    chk("cont_ack", 32'(physAck), 32'(1));
                    chk("cont_data", 32'(physBlockType), 32'(mem[pa]));
                end
                if (h == 208) chk("cont_ack_pulse", 32'(physAck), 32'(0));
            end
        end
    endtask

    initial begin
        int n_mem, bad, lvl;
        for (int a = 0; a < 2048; a++) mem[a] = 3'($urandom);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++) mem[r * 20 + c] = 3'((c + r) % 4);

        reset = 1'b1; frameStart = 1'b0; levelSel = 2'd0;
        physReq = 1'b1; physCol = 5'd3; physRow = 4'd2;
        hCount = 10'd200; vCount = 10'd75;
        for (int i = 0; i < 3; i++) begin
            hCount = 10'(200 + 40 * i);
            tick();
            chk("rst_blockType", 32'(blockType), 32'(0));
            chk("rst_physAck", 32'(physAck), 32'(0));
            chk("rst_physBlockType", 32'(physBlockType), 32'(0));
            chk("rst_memEn", 32'(memEn), 32'(0));
            chk("rst_memAddr", 32'(memAddr), 32'(0));
        end
        reset = 1'b0; physReq = 1'b0;

        // Level 0 pattern, two lines: steady state is 20 display reads per line
        set_level(0);
        sweep_line(75, 0, 1'b0, n_mem, bad);
        chk("line1_reads", 32'(n_mem), 32'(21));
        sweep_line(75, 0, 1'b0, n_mem, bad);
        chk("line2_reads", 32'(n_mem), 32'(20));
        chk("line2_range", 32'(bad), 32'(0));

        set_level(1);
        phys_txn(3, 2, 1);
        phys_txn(25, 2, 1);

        for (int i = 0; i < 8; i++) begin
            lvl = $urandom_range(0, 3);
            set_level(lvl);
            phys_txn($urandom_range(0, 24), $urandom_range(0, 15), lvl);
        end

        lvl = $urandom_range(0, 3);
        set_level(lvl);
        sweep_line(120, lvl, 1'b1, n_mem, bad);

        // levelSel moves mid-frame; only the next frameStart may apply it
        set_level(0);
        levelSel = 2'd2;
        sweep_line(100, 0, 1'b0, n_mem, bad);
        chk("midframe_reads", 32'(n_mem), 32'(21));
        chk("midframe_range", 32'(bad), 32'(0));
        set_level(2);
        sweep_line(100, 2, 1'b0, n_mem, bad);
        chk("newlevel_reads", 32'(n_mem), 32'(21));
        chk("newlevel_range", 32'(bad), 32'(0));

        // Reset during an outstanding physics read drops it silently
        hCount = 10'd0; vCount = 10'd0;
        physCol = 5'd1; physRow = 4'd1; physReq = 1'b1;
        tick();
        chk("rmid_memEn", 32'(memEn), 32'(1));
        reset = 1'b1;
        tick();
        chk("rmid_memEn_clr", 32'(memEn), 32'(0));
        reset = 1'b0; physReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rmid_no_ack", 32'(physAck), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
